pipeline_ctrl: RTL and testbench

//   Sequences the five-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
//   Per cycle, drives an enable and a flush for each latch, based on cache hits,

---
 rtl/pipeline_ctrl_if.sv | 41 ++++
 rtl/pipeline_ctrl.sv | 137 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Hazard/status inputs and latch/PC control outputs between the pipeline controller and the datapath.
// master = pipeline_ctrl, slave = datapath side.
interface pipeline_ctrl_if;
  logic       ihit;
  logic       dhit;
  logic       ex_memread;
  logic [4:0] ex_dest;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       mem_dren;
  logic       mem_dwen;
  logic       mem_xfer;
  logic       mem_halt;

  logic       pc_en;
  logic       pc_redirect;
  logic       ifid_en;
  logic       ifid_flush;
  logic       idex_en;
  logic       idex_flush;
  logic       exmem_en;
  logic       exmem_flush;
  logic       memwb_en;
  logic       memwb_flush;
  logic       halt;

  modport master (
    input  ihit, dhit, ex_memread, ex_dest, id_rs, id_rt, id_uses_rt,
           mem_dren, mem_dwen, mem_xfer, mem_halt,
    output pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, exmem_flush, memwb_en, memwb_flush, halt
  );

  modport slave (
    output ihit, dhit, ex_memread, ex_dest, id_rs, id_rt, id_uses_rt,
           mem_dren, mem_dwen, mem_xfer, mem_halt,
    input  pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, exmem_flush, memwb_en, memwb_flush, halt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline latch/PC sequencer: cache-miss stalls, load-use bubbles, MEM-resolved redirects, halt.
// Optional macro PIPE_PERF_EN adds stall_cnt/flush_cnt performance counters.
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  pipeline_ctrl_if.master   bus
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DWAIT  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pipeline_ctrl: CNT_W must be at least 1");
  end

  logic [1:0] state;
  logic [1:0] next_state;
  logic       halt_q;

  logic dreq;
  logic load_use;
  logic run_rules;
  logic xfer_fire;

  logic pc_en, pc_redirect;
  logic ifid_en, ifid_flush, idex_en, idex_flush;
  logic exmem_en, exmem_flush, memwb_en, memwb_flush;

  assign dreq     = bus.mem_dren | bus.mem_dwen;
  // r0 is hardwired zero, so a load targeting it never creates a real dependency.
  assign load_use = bus.ex_memread && (bus.ex_dest != 5'd0) &&
                    ((bus.ex_dest == bus.id_rs) ||
                     (bus.id_uses_rt && (bus.ex_dest == bus.id_rt)));

  always_comb begin
    next_state  = state;
    run_rules   = 1'b0;
    xfer_fire   = 1'b0;
    pc_en       = 1'b0;
    pc_redirect = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    memwb_flush = 1'b0;

    case (state)
      ST_RUN: begin
        if (dreq && !bus.dhit) next_state = ST_DWAIT;
        else                   run_rules  = 1'b1;
      end
      ST_DWAIT: begin
        // Completing access is treated exactly like a RUN cycle whose request just finished.
        if (bus.dhit) begin
          next_state = ST_RUN;
          run_rules  = 1'b1;
        end
      end
      ST_HALTED: next_state = ST_HALTED;
      default:   next_state = ST_RUN;
    endcase

    if (run_rules) begin
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      if (bus.mem_halt) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        next_state  = ST_HALTED;
      end else if (bus.mem_xfer) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        pc_en       = 1'b1;
        pc_redirect = 1'b1;
        xfer_fire   = 1'b1;
      end else if (load_use) begin
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (!bus.ihit) begin
        ifid_flush = 1'b1;
      end else begin
        pc_en = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= ST_RUN;
      halt_q <= 1'b0;
    end else begin
      state  <= next_state;
      halt_q <= (next_state == ST_HALTED);
    end
  end

`ifdef PIPE_PERF_EN
  // Counters freeze once halted; wrap is the natural modulo-2^CNT_W overflow.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state != ST_HALTED) begin
      if (!pc_en)    stall_cnt <= stall_cnt + 1'b1;
      if (xfer_fire) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

  assign bus.pc_en       = pc_en;
  assign bus.pc_redirect = pc_redirect;
  assign bus.ifid_en     = ifid_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_en     = idex_en;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_en    = exmem_en;
  assign bus.exmem_flush = exmem_flush;
  assign bus.memwb_en    = memwb_en;
  assign bus.memwb_flush = memwb_flush;
  assign bus.halt        = halt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: reset, D-cache wait, load-use, redirect, halt, fetch stall.
// Control vector order: {pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush}.
module tb_pipeline_ctrl;
  localparam int CNT_W = 32;

  localparam logic [9:0] V_NORMAL = 10'b10_1010_1010;
  localparam logic [9:0] V_STALL  = 10'b00_0000_0000;
  localparam logic [9:0] V_DRAIN  = 10'b00_1111_1110;
  localparam logic [9:0] V_XFER   = 10'b11_1111_1110;
  localparam logic [9:0] V_LU     = 10'b00_0011_1010;
  localparam logic [9:0] V_NOIHIT = 10'b00_1110_1010;

  logic CLK;
  logic nRST;
  int   vectors;
  int   miscompares;

  pipeline_ctrl_if bus();

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
`endif

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .bus      (bus.master)
`ifdef PIPE_PERF_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [9:0] ctl();
    return {bus.pc_en, bus.pc_redirect, bus.ifid_en, bus.ifid_flush, bus.idex_en,
            bus.idex_flush, bus.exmem_en, bus.exmem_flush, bus.memwb_en, bus.memwb_flush};
  endfunction

  task automatic idle();
    bus.ihit       = 1'b1;
    bus.dhit       = 1'b0;
    bus.ex_memread = 1'b0;
    bus.ex_dest    = 5'd0;
    bus.id_rs      = 5'd0;
    bus.id_rt      = 5'd0;
    bus.id_uses_rt = 1'b0;
    bus.mem_dren   = 1'b0;
    bus.mem_dwen   = 1'b0;
    bus.mem_xfer   = 1'b0;
    bus.mem_halt   = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    idle();
    nRST = 1'b0;
    #2;
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    idle();
    nRST = 1'b0;
    #2;
    vectors++;
    if (bus.halt !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_halt: got %b expected 0", bus.halt);
    end
    vectors++;
    if (ctl() !== V_NORMAL) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b expected %b", ctl(), V_NORMAL);
    end
`ifdef PIPE_PERF_EN
    vectors++;
    if (stall_cnt !== '0 || flush_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
    end
`endif
    @(negedge CLK);
    nRST = 1'b1;
    #2;
    vectors++;
    if (ctl() !== V_NORMAL) begin
      miscompares++;
      $display("FAIL run_normal: got %b expected %b", ctl(), V_NORMAL);
    end
  endtask

  task automatic test_dwait();
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      idle();
      bus.mem_dren = 1'b1;
      #2;
      vectors++;
      if (ctl() !== V_STALL) begin
        miscompares++;
        $display("FAIL dwait_miss%0d: got %b expected %b", c, ctl(), V_STALL);
      end
    end
    @(negedge CLK);
    bus.dhit = 1'b1;
    #2;
    vectors++;
    if (ctl() !== V_NORMAL) begin
      miscompares++;
      $display("FAIL dwait_hit: got %b expected %b", ctl(), V_NORMAL);
    end
    // Back in RUN: a stray dhit without a request changes nothing.
    @(negedge CLK);
    idle();
    bus.dhit = 1'b1;
    #2;
    vectors++;
    if (ctl() !== V_NORMAL) begin
      miscompares++;
      $display("FAIL stray_dhit: got %b expected %b", ctl(), V_NORMAL);
    end
    // Store miss, then dhit together with an ifetch miss.
    @(negedge CLK);
    idle();
    bus.mem_dwen = 1'b1;
    #2;
    vectors++;
    if (ctl() !== V_STALL) begin
      miscompares++;
      $display("FAIL store_miss: got %b expected %b", ctl(), V_STALL);
    end
    @(negedge CLK);
    bus.dhit = 1'b1;
    bus.ihit = 1'b0;
    #2;
    vectors++;
    if (ctl() !== V_NOIHIT) begin
      miscompares++;
      $display("FAIL dhit_with_imiss: got %b expected %b", ctl(), V_NOIHIT);
    end
    // Async reset while parked in DWAIT.
    @(negedge CLK);
    idle();
    bus.mem_dren = 1'b1;
    @(negedge CLK);
    bus.mem_dren = 1'b0;
    #2;
    vectors++;
    if (ctl() !== V_STALL) begin
      miscompares++;
      $display("FAIL dwait_hold: got %b expected %b", ctl(), V_STALL);
    end
    nRST = 1'b0;
    #1;
    vectors++;
    if (ctl() !== V_NORMAL) begin
      miscompares++;
      $display("FAIL reset_mid_stall: got %b expected %b", ctl(), V_NORMAL);
    end
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_load_use();
    @(negedge CLK);
    idle();
    bus.ex_memread = 1'b1;
    bus.ex_dest    = 5'd8;
    bus.id_rs      = 5'd8;
    #2;
    vectors++;
    if (ctl() !== V_LU) begin
      miscompares++;
      $display("FAIL lu_rs: got %b expected %b", ctl(), V_LU);
    end
    @(negedge CLK);
    bus.ex_dest = 5'd0;
    bus.id_rs   = 5'd0;
    #2;
    vectors++;
    if (ctl() !== V_NORMAL) begin
      miscompares++;
      $display("FAIL lu_r0: got %b expected %b", ctl(), V_NORMAL);
    end
    @(negedge CLK);
    bus.ex_dest    = 5'd9;
    bus.id_rs      = 5'd3;
    bus.id_rt      = 5'd9;
    bus.id_uses_rt = 1'b1;
    #2;
    vectors++;
    if (ctl() !== V_LU) begin
      miscompares++;
      $display("FAIL lu_rt: got %b expected %b", ctl(), V_LU);
    end
    @(negedge CLK);
    bus.id_uses_rt = 1'b0;
    #2;
    vectors++;
    if (ctl() !== V_NORMAL) begin
      miscompares++;
      $display("FAIL lu_rt_unused: got %b expected %b", ctl(), V_NORMAL);
    end
    @(negedge CLK);
    bus.id_uses_rt = 1'b1;
    bus.ex_memread = 1'b0;
    #2;
    vectors++;
    if (ctl() !== V_NORMAL) begin
      miscompares++;
      $display("FAIL lu_not_load: got %b expected %b", ctl(), V_NORMAL);
    end
  endtask

  task automatic test_xfer();
    pulse_reset();
    @(negedge CLK);
    idle();
    bus.ex_memread = 1'b1;
    bus.ex_dest    = 5'd8;
    bus.id_rs      = 5'd8;
    bus.ihit       = 1'b0;
    bus.mem_xfer   = 1'b1;
    #2;
    vectors++;
    if (ctl() !== V_XFER) begin
      miscompares++;
      $display("FAIL xfer_over_lu: got %b expected %b", ctl(), V_XFER);
    end
    @(negedge CLK);
    idle();
    #2;
    vectors++;
    if (ctl() !== V_NORMAL) begin
      miscompares++;
      $display("FAIL after_xfer: got %b expected %b", ctl(), V_NORMAL);
    end
`ifdef PIPE_PERF_EN
    vectors++;
    if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL xfer_cnt: got flush %0d stall %0d expected 1/0", flush_cnt, stall_cnt);
    end
`endif
  endtask

  task automatic test_halt();
    @(negedge CLK);
    idle();
    bus.mem_halt = 1'b1;
    #2;
    vectors++;
    if (ctl() !== V_DRAIN || bus.halt !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_drain: got %b/%b expected %b/0", ctl(), bus.halt, V_DRAIN);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      idle();
      bus.dhit     = 1'b1;
      bus.mem_dren = (c == 1);
      bus.mem_xfer = (c == 1);
      #2;
      vectors++;
      if (ctl() !== V_STALL || bus.halt !== 1'b1) begin
        miscompares++;
        $display("FAIL halted%0d: got %b/%b expected %b/1", c, ctl(), bus.halt, V_STALL);
      end
    end
    pulse_reset();
    #1;
    vectors++;
    if (ctl() !== V_NORMAL || bus.halt !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_cleared: got %b/%b expected %b/0", ctl(), bus.halt, V_NORMAL);
    end
  endtask

  task automatic test_ihit_stall();
    pulse_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      idle();
      bus.ihit = 1'b0;
      #2;
      vectors++;
      if (ctl() !== V_NOIHIT) begin
        miscompares++;
        $display("FAIL imiss%0d: got %b expected %b", c, ctl(), V_NOIHIT);
      end
    end
    @(negedge CLK);
    idle();
    #2;
    vectors++;
    if (ctl() !== V_NORMAL) begin
      miscompares++;
      $display("FAIL imiss_done: got %b expected %b", ctl(), V_NORMAL);
    end
`ifdef PIPE_PERF_EN
    vectors++;
    if (stall_cnt !== 32'd2) begin
      miscompares++;
      $display("FAIL stall_cnt: got %0d expected 2", stall_cnt);
    end
`endif
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    nRST        = 1'b1;
    idle();
    test_reset();
    test_dwait();
    test_load_use();
    test_xfer();
    test_halt();
    test_ihit_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not complete, expected finish before 20000");
    $fatal(1);
  end
endmodule
